seg7_scan_driver: RTL and testbench

//  Downstream display stage of the kitchen timer. Consumes the FSM's four BCD digits
//  (min_1,min_0,sec_1,sec_0) and its led alarm flag. Drives a 4-digit common-anode
//  7-segment display by time-multiplexing: one digit lit per slot, anode/segment

---
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows the timer's BCD digits from a per-frame snapshot and blinks the display while the alarm is up.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned BLANK_LZ     = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] min_1,
  input  logic [3:0] min_0,
  input  logic [3:0] sec_1,
  input  logic [3:0] sec_0,
  input  logic       led,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned TW = $clog2(REFRESH_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TickLast  = TW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FrameLast = FW'(BLINK_FRAMES - 1);

  typedef enum logic [0:0] {StLit, StDark} phase_e;

  logic [TW-1:0]    tick_q, tick_d;
  logic [1:0]       idx_q, idx_d;
  logic [FW-1:0]    frame_q, frame_d;
  phase_e           phase_q, phase_d;
  logic             armed_q;
  logic [3:0][3:0]  snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             slot_end;
  logic             frame_wrap;
  logic [3:0]       digit;
  logic             lz_blank;
  logic             lit;

  function automatic logic [6:0] decode(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  // Scan counters and frame snapshot
  always_comb begin
    slot_end   = (tick_q == TickLast);
    frame_wrap = slot_end && (idx_q == 2'd3);
    tick_d     = slot_end ? '0 : tick_q + TW'(1);
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
    snap_d     = snap_q;
    // Capture once right after reset, then only at frame boundaries so a frame never mixes updates.
    if (!armed_q || frame_wrap) begin
      snap_d = {min_1, min_0, sec_1, sec_0};
    end
  end

  // Blink phase: a dropped alarm clears immediately, even on a wrap edge
  always_comb begin
    phase_d = phase_q;
    frame_d = frame_q;
    if (!led) begin
      phase_d = StLit;
      frame_d = '0;
    end else if (frame_wrap) begin
      if (frame_q == FrameLast) begin
        frame_d = '0;
        phase_d = (phase_q == StLit) ? StDark : StLit;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
  end

  // Output next-state, from the current slot; tick 0 of every slot is a ghosting blank
  always_comb begin
    digit    = snap_q[idx_q];
    seg_d    = decode(digit);
    lz_blank = (BLANK_LZ != 0) && (idx_q == 2'd3) && (snap_q[3] == 4'd0);
    lit      = (tick_q != '0) && (phase_q == StLit) && !lz_blank;
    an_d     = lit ? ~(4'b0001 << idx_q) : 4'b1111;
    dp_d     = !(lit && (idx_q == 2'd2));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q  <= '0;
      idx_q   <= 2'd0;
      frame_q <= '0;
      phase_q <= StLit;
      armed_q <= 1'b0;
      snap_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      armed_q <= 1'b1;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_FRAMES=2, BLANK_LZ=1.
// k counts rising edges since reset release; outputs are sampled on the falling edge after edge k.
module tb_seg7_scan_driver;

  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] min_1, min_0, sec_1, sec_0;
  logic       led;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  // Expected anode per cycle of a frame (index = k-1 within frame)
  logic [3:0] an_a [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                            4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  logic [3:0] an_c [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                            4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF};
  // Expected segments per slot (idx 0..3)
  logic [6:0] seg_a [4] = '{S4, S3, S2, S1};
  logic [6:0] seg_c [4] = '{S9, DASH, S5, 7'h00};

  seg7_scan_driver #(
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2),
    .BLANK_LZ    (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .min_1(min_1),
    .min_0(min_0),
    .sec_1(sec_1),
    .sec_0(sec_0),
    .led  (led),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  initial begin
    reset = 1'b1;
    led   = 1'b0;
    min_1 = 4'd1;
    min_0 = 4'd2;
    sec_1 = 4'd3;
    sec_0 = 4'd4;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    reset = 1'b0;
    k = 0;

    // Frame A: digits 1,2,3,4 full scan
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("a_an%0d", n), 32'(an), 32'(an_a[n-1]));
      if (an_a[n-1] != 4'hF) check($sformatf("a_seg%0d", n), 32'(seg), 32'(seg_a[(n-1)/4]));
      check($sformatf("a_dp%0d", n), 32'(dp), (n >= 10 && n <= 12) ? 32'd0 : 32'd1);
    end

    // New digits land only at the next frame wrap
    min_1 = 4'd0;
    min_0 = 4'd5;
    sec_1 = 4'hC;
    sec_0 = 4'd9;
    run_to(18);
    check("b_an_old", 32'(an), 32'hE);
    check("b_seg_old", 32'(seg), 32'(S4));
    run_to(30);
    check("b_an_min1", 32'(an), 32'h7);
    check("b_seg_min1", 32'(seg), 32'(S1));
    run_to(32);

    // Frame C: leading zero blanked, dash for 0xC
    for (int n = 1; n <= 16; n++) begin
      tick();
      check($sformatf("c_an%0d", n), 32'(an), 32'(an_c[n-1]));
      if (an_c[n-1] != 4'hF) check($sformatf("c_seg%0d", n), 32'(seg), 32'(seg_c[(n-1)/4]));
      check($sformatf("c_dp%0d", n), 32'(dp), (n >= 10 && n <= 12) ? 32'd0 : 32'd1);
    end

    // Mid-frame change of sec_0 3->7 stays hidden until the next wrap
    sec_0 = 4'd3;
    run_to(66);
    check("d_an", 32'(an), 32'hE);
    check("d_seg3", 32'(seg), 32'(S3));
    sec_0 = 4'd7;
    run_to(68);
    check("d_seg3_hold", 32'(seg), 32'(S3));
    run_to(82);
    check("d_an_new", 32'(an), 32'hE);
    check("d_seg7_new", 32'(seg), 32'(S7));

    // Blink: lit k=97..128, dark 129..160, lit 161..192, dark 193..
    run_to(96);
    led = 1'b1;
    run_to(114);
    check("e_lit_an", 32'(an), 32'hE);
    run_to(124);
    check("e_lit_an2", 32'(an), 32'hB);
    check("e_lit_dp", 32'(dp), 32'd0);
    run_to(130);
    check("e_dark_an", 32'(an), 32'hF);
    check("e_dark_seg", 32'(seg), 32'(S7));
    run_to(139);
    check("e_dark_an2", 32'(an), 32'hF);
    check("e_dark_dp", 32'(dp), 32'd1);
    run_to(146);
    check("e_dark_an3", 32'(an), 32'hF);
    run_to(162);
    check("e_relit_an", 32'(an), 32'hE);
    run_to(194);
    check("e_dark2_an", 32'(an), 32'hF);
    run_to(200);
    led = 1'b0;
    run_to(201);
    check("e_drop_an1", 32'(an), 32'hF);
    run_to(202);
    check("e_drop_an2", 32'(an), 32'hB);
    check("e_drop_dp", 32'(dp), 32'd0);

    // Reset while dark on the min_0 slot
    led = 1'b1;
    run_to(234);
    check("f_dark_an", 32'(an), 32'hF);
    check("f_dark_dp", 32'(dp), 32'd1);
    reset = 1'b1;
    run_to(235);
    check("f_rst_an", 32'(an), 32'hF);
    check("f_rst_seg", 32'(seg), 32'h7F);
    check("f_rst_dp", 32'(dp), 32'd1);
    reset = 1'b0;
    run_to(236);
    check("f_blank_an", 32'(an), 32'hF);
    run_to(237);
    check("f_idx0_an", 32'(an), 32'hE);
    check("f_idx0_seg", 32'(seg), 32'(S7));
    led = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
